core_sequencer: RTL and testbench

Supervisor that sits directly upstream of the processor top level. It streams a program image from a host into the instruction memory write port over a valid/ready handshake, and holds the core in init. It then releases the core for one run, measures the run length in cycles until the core raises its halt flag, and reports completion to the host. It owns the core's `start` input; the core's `halt` output is its completion source.

---
 rtl/core_sequencer.sv | 148 ++++++++++++++
 tb/tb_core_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Program loader and run supervisor that sits in front of the processor core.
// Optional run watchdog is enabled by defining CORE_SEQ_WATCHDOG_EN.
module core_sequencer #(
   parameter int          IW           = 9,
   parameter int          AW           = 10,
   parameter int          START_CYCLES = 2,
   parameter logic [15:0] TIMEOUT      = 16'd50000
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [IW-1:0] ld_data,
   input  logic          ld_last,
   input  logic          go,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [IW-1:0] im_data,
   output logic          core_start,
   input  logic          core_halt,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [15:0]   cycle_count,
   output logic [AW:0]   load_count
);

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   localparam logic [AW:0] FULL      = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};
   localparam logic [3:0]  START_LEN = 4'(START_CYCLES);

   state_t      state;
   logic [AW:0] wp;
   logic [3:0]  start_cnt;
   logic [15:0] count_sat;
   logic        accept;

   assign accept    = ld_valid & ld_ready;
   assign count_sat = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;

`ifndef CORE_SEQ_WATCHDOG_EN
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wp          <= '0;
         start_cnt   <= '0;
         ld_ready    <= 1'b1;
         core_start  <= 1'b1;
         im_we       <= 1'b0;
         im_addr     <= '0;
         im_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         load_count  <= '0;
      end else begin
         im_we <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  im_we   <= 1'b1;
                  im_addr <= wp[AW-1:0];
                  im_data <= ld_data;
                  if (ld_last) begin
                     load_count <= wp + ONE;
                     wp         <= '0;
                  end else begin
                     wp       <= wp + ONE;
                     ld_ready <= (wp + ONE) != FULL;
                  end
               end else if (go) begin
                  // A full memory without ld_last still counts as a complete image
                  if (wp == FULL)
                     load_count <= FULL;
                  state       <= START;
                  busy        <= 1'b1;
                  ld_ready    <= 1'b0;
                  start_cnt   <= 4'd1;
                  cycle_count <= '0;
                  timeout     <= 1'b0;
               end
            end
            START: begin
               if (start_cnt == START_LEN) begin
                  state      <= RUN;
                  core_start <= 1'b0;
               end else begin
                  start_cnt <= start_cnt + 4'd1;
               end
            end
            RUN: begin
               if (core_halt) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  ld_ready <= 1'b1;
               end else begin
                  cycle_count <= count_sat;
`ifdef CORE_SEQ_WATCHDOG_EN
                  if (count_sat == TIMEOUT) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     ld_ready <= 1'b1;
                     timeout  <= 1'b1;
                  end
`endif
               end
            end
            DONE: begin
               if (accept) begin
                  // A beat after a run always starts a fresh image at address 0
                  im_we      <= 1'b1;
                  im_addr    <= '0;
                  im_data    <= ld_data;
                  state      <= IDLE;
                  done       <= 1'b0;
                  core_start <= 1'b1;
                  if (ld_last) begin
                     load_count <= ONE;
                     wp         <= '0;
                  end else begin
                     wp <= ONE;
                  end
               end else if (go) begin
                  state       <= START;
                  done        <= 1'b0;
                  busy        <= 1'b1;
                  core_start  <= 1'b1;
                  ld_ready    <= 1'b0;
                  start_cnt   <= 4'd1;
                  cycle_count <= '0;
                  timeout     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed testbench for core_sequencer: load, run, coincident go/beat, full fill,
// watchdog behaviour of the current build, and asynchronous reset mid-run.
module tb_core_sequencer;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [8:0]  ld_data = '0;
   logic        ld_last = 1'b0;
   logic        go = 1'b0;
   logic        im_we;
   logic [9:0]  im_addr;
   logic [8:0]  im_data;
   logic        core_start;
   logic        core_halt = 1'b0;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] cycle_count;
   logic [10:0] load_count;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   core_sequencer #(.IW(9), .AW(10), .START_CYCLES(2), .TIMEOUT(16'd100)) dut (
      .CLK(CLK), .reset(reset),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .go(go),
      .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
      .core_start(core_start), .core_halt(core_halt),
      .busy(busy), .done(done), .timeout(timeout),
      .cycle_count(cycle_count), .load_count(load_count)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;

      // reset state
      tick(); tick();
      check("rst_ld_ready", ld_ready, 1);
      check("rst_core_start", core_start, 1);
      check("rst_im_we", im_we, 0);
      check("rst_im_addr", im_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_cycle_count", cycle_count, 0);
      check("rst_load_count", load_count, 0);
      reset = 1'b0;
      tick();

      // four-word image
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = 9'h101 + 9'(i);
         ld_last  = (i == 3);
         tick();
         check("load_we", im_we, 1);
         check("load_addr", im_addr, i);
         check("load_data", im_data, 32'h101 + i);
         $display("load beat %0d addr=%0d data=%0h", i, im_addr, im_data);
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      check("load_we_idle", im_we, 0);
      check("load_count4", load_count, 4);

      // run of 37 cycles
      go = 1'b1;
      tick();
      go = 1'b0;
      check("go_busy", busy, 1);
      n = 0;
      while (core_start === 1'b1 && n < 10) begin
         tick();
         n++;
      end
      check("start_len", n, 2);
      repeat (37) tick();
      check("run_count37", cycle_count, 37);
      check("run_done0", done, 0);
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
      check("halt_done", done, 1);
      check("halt_busy", busy, 0);
      check("halt_count", cycle_count, 37);
      check("halt_core_start", core_start, 0);
      check("halt_ld_ready", ld_ready, 1);
      $display("run1 cycles=%0d done=%0b", cycle_count, done);

      // beat and go coincide in DONE, then again in IDLE
      ld_valid = 1'b1; ld_data = 9'h0AA; go = 1'b1;
      tick();
      check("done_beat_we", im_we, 1);
      check("done_beat_addr", im_addr, 0);
      check("done_beat_done", done, 0);
      check("done_beat_start", core_start, 1);
      ld_data = 9'h0BB; ld_last = 1'b1;
      tick();
      check("idle_coinc_we", im_we, 1);
      check("idle_coinc_addr", im_addr, 1);
      check("idle_coinc_busy", busy, 0);
      check("idle_coinc_lc", load_count, 2);
      ld_valid = 1'b0; ld_last = 1'b0;
      tick();
      go = 1'b0;
      check("coinc_start_busy", busy, 1);
      core_halt = 1'b1;
      tick();
      check("start_ignores_halt", busy, 1);
      tick();
      check("run_entry_cs", core_start, 0);
      tick();
      core_halt = 1'b0;
      check("immediate_halt_done", done, 1);
      check("immediate_halt_cc", cycle_count, 0);
      $display("coincident go/beat run done=%0b cycles=%0d", done, cycle_count);

      // fill all 1024 addresses without ld_last
      for (int i = 0; i < 1024; i++) begin
         ld_valid = 1'b1;
         ld_data  = 9'(i);
         tick();
         if (i == 1023) begin
            check("fill_last_addr", im_addr, 1023);
            check("fill_ready_low", ld_ready, 0);
         end
      end
      tick();
      check("fill_stall_we", im_we, 0);
      ld_valid = 1'b0;
      go = 1'b1;
      tick();
      go = 1'b0;
      check("fill_go_busy", busy, 1);
      check("fill_load_count", load_count, 1024);
      tick(); tick();
      repeat (5) tick();
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
      check("fill_run_done", done, 1);
      check("fill_run_cc", cycle_count, 5);
      $display("full image run load_count=%0d cycles=%0d", load_count, cycle_count);

      // core that never halts
      go = 1'b1;
      tick();
      go = 1'b0;
      tick(); tick();
      repeat (100) tick();
      check("wd_cc", cycle_count, 100);
`ifdef CORE_SEQ_WATCHDOG_EN
      check("wd_done", done, 1);
      check("wd_timeout", timeout, 1);
      check("wd_busy", busy, 0);
`else
      check("nowd_busy", busy, 1);
      check("nowd_timeout", timeout, 0);
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
`endif
      $display("no-halt run cycles=%0d timeout=%0b", cycle_count, timeout);

      // reset in the middle of a run
      go = 1'b1;
      tick();
      go = 1'b0;
      check("rerun_timeout_clr", timeout, 0);
      tick(); tick();
      repeat (20) tick();
      check("pre_reset_cc", cycle_count, 20);
      #3 reset = 1'b1;
      #1;
      check("areset_core_start", core_start, 1);
      check("areset_busy", busy, 0);
      check("areset_done", done, 0);
      check("areset_cc", cycle_count, 0);
      check("areset_lc", load_count, 0);
      #1 reset = 1'b0;
      tick();
      go = 1'b1;
      tick();
      go = 1'b0;
      check("post_reset_busy", busy, 1);
      tick(); tick();
      repeat (3) tick();
      core_halt = 1'b1;
      tick();
      core_halt = 1'b0;
      check("post_reset_done", done, 1);
      check("post_reset_cc", cycle_count, 3);
      $display("post-reset run cycles=%0d", cycle_count);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
